// File: rtl/swap_buffer_ctrl_if.sv
// Dual-lane valid/ready bus plus mode-control sideband for the swap/buffer lane.
// The slave modport is the lane itself; master is the producer/consumer/controller side.
interface swap_buffer_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aout;
  logic [WIDTH-1:0] bout;
  logic             swap_req;
  logic             sel;
  logic             busy;
  logic [7:0]       swap_cnt;

  modport slave (
    input  in_valid, a_in, b_in, out_ready, swap_req,
    output in_ready, out_valid, aout, bout, sel, busy, swap_cnt
  );

  modport master (
    output in_valid, a_in, b_in, out_ready, swap_req,
    input  in_ready, out_valid, aout, bout, sel, busy, swap_cnt
  );
endinterface

// File: rtl/swap_buffer_ctrl.sv
// Registered swap/buffer lane: beats pass straight or crossed, and mode changes
// are sequenced RUN -> DRAIN -> SWITCH so no beat ever straddles a mode change.
module swap_buffer_ctrl #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  swap_buffer_ctrl_if.slave   bus
);
  localparam int HW = $clog2(HOLD_MIN + 1);

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

  state_t           state;
  logic             sel_r;
  logic             pending;
  logic [HW-1:0]    hold_cnt;
  logic [7:0]       swap_cnt_r;
  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;

  logic             pend_eff;
  logic             hold_done;
  logic             in_ready_c;
  logic             accept;

  // Returns {aout, bout} for the given mode.
  function automatic logic [2*WIDTH-1:0] lane_mux(input logic s,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    return s ? {b, a} : {a, b};
  endfunction

  assign pend_eff   = pending | bus.swap_req;
  assign hold_done  = (hold_cnt == '0);
  assign in_ready_c = (state == RUN) && !(pend_eff && hold_done) && (!vld_p1 || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.aout      = a_p1;
  assign bus.bout      = b_p1;
  assign bus.sel       = sel_r;
  assign bus.busy      = (state != RUN);
  assign bus.swap_cnt  = swap_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      sel_r      <= 1'b0;
      pending    <= 1'b0;
      hold_cnt   <= '0;
      swap_cnt_r <= 8'd0;
      vld_p1     <= 1'b0;
      a_p1       <= '0;
      b_p1       <= '0;
    end else begin
      // Stage p1: output register, muxed with the mode in force at accept
      if (accept) begin
        vld_p1       <= 1'b1;
        {a_p1, b_p1} <= lane_mux(sel_r, bus.a_in, bus.b_in);
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end

      case (state)
        RUN: begin
          if (!hold_done)
            hold_cnt <= hold_cnt - HW'(1);
          if (pend_eff && hold_done) begin
            state   <= DRAIN;
            pending <= 1'b0;
          end else if (bus.swap_req) begin
            pending <= 1'b1;
          end
        end
        DRAIN: begin
          // Requests arriving here are dropped; the caller re-requests after busy falls.
          if (!vld_p1 || bus.out_ready)
            state <= SWITCH;
        end
        SWITCH: begin
          sel_r      <= ~sel_r;
          swap_cnt_r <= swap_cnt_r + 8'd1;
          hold_cnt   <= HW'(HOLD_MIN);
          state      <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
